// File: rtl/servo_pkg.sv
// Shared types and default timing constants for the servo PWM generator.
package servo_pkg;

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;

    localparam int DEF_PRESCALE     = 50;
    localparam int DEF_PERIOD_TICKS = 20000;
    localparam int DEF_MIN_PULSE    = 1000;
    localparam int DEF_MAX_PULSE    = 2000;

    // Servo neutral: midpoint of the pulse range.
    function automatic logic [15:0] neutral_width(input int min_p, input int max_p);
        return 16'(min_p + ((max_p - min_p) >> 1));
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: one-cycle tick every PRESCALE clocks while run is high, held at 0 otherwise.
module tick_gen #(
    parameter int PRESCALE = 50
) (
    input  logic clk_i,
    input  logic reset,
    input  logic run,
    output logic tick
);
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = run && (cnt_q == CW'(PRESCALE - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (!run || tick) cnt_d = '0;
        else              cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/servo_pwm_gen.sv
// Hobby-servo PWM frame generator: maps the PID duty word to a pulse width that is
// only swapped in at frame boundaries, and flags updates that were overwritten.
module servo_pwm_gen
    import servo_pkg::*;
#(
    parameter int WIDTH        = 12,
    parameter int PRESCALE     = DEF_PRESCALE,
    parameter int PERIOD_TICKS = DEF_PERIOD_TICKS,
    parameter int MIN_PULSE    = DEF_MIN_PULSE,
    parameter int MAX_PULSE    = DEF_MAX_PULSE
) (
    input  logic             clk_i,
    input  logic             reset,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] duty_i,
    input  logic             duty_valid_i,
    output logic             pwm_o,
    output logic             frame_o,
    output logic [15:0]      pulse_ticks_o,
    output logic             ovr_o
);
    localparam logic [15:0] NEUTRAL = neutral_width(MIN_PULSE, MAX_PULSE);
    localparam int          PW      = WIDTH + 16;

    state_e      state_q, state_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic [15:0] active_q, active_d;
    logic [15:0] pend_q, pend_d;
    logic        applied_q, applied_d;
    logic        ovr_q, ovr_d;
    logic        pwm_q, pwm_d;
    logic        frame_q, frame_d;

    logic          run, tick, frame_end, frame_start;
    logic [PW-1:0] prod;
    logic [15:0]   mapped;

    assign run = (state_q != IDLE);

    tick_gen #(.PRESCALE(PRESCALE)) u_tick (
        .clk_i (clk_i),
        .reset (reset),
        .run   (run),
        .tick  (tick)
    );

    // Full-width product so the shift sees every bit of the scaled duty.
    assign prod   = PW'(duty_i) * PW'(MAX_PULSE - MIN_PULSE);
    assign mapped = 16'(MIN_PULSE) + 16'(prod >> WIDTH);

    always_comb begin
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        active_d    = active_q;
        frame_start = 1'b0;
        frame_end   = tick && (tcnt_q == 16'(PERIOD_TICKS - 1));

        if (state_q == IDLE) begin
            frame_start = enable_i;
        end else begin
            if (tick) tcnt_d = frame_end ? 16'd0 : tcnt_q + 16'd1;
            if (frame_end) begin
                if (enable_i) frame_start = 1'b1;
                else          state_d     = IDLE;
            end
        end

        if (frame_start) begin
            state_d  = HIGH;
            tcnt_d   = 16'd0;
            active_d = pend_q;
        end

        if (state_d == HIGH && tcnt_d >= active_d) state_d = LOW;

        pwm_d   = (state_d == HIGH);
        frame_d = frame_start;
    end

    // A strobe on the frame-start cycle does not collide: the old value is being applied now.
    always_comb begin
        pend_d    = pend_q;
        applied_d = applied_q;
        ovr_d     = ovr_q;
        if (frame_start) applied_d = 1'b1;
        if (duty_valid_i) begin
            if (!applied_q && !frame_start) ovr_d = 1'b1;
            pend_d    = mapped;
            applied_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q   <= IDLE;
            tcnt_q    <= 16'd0;
            active_q  <= NEUTRAL;
            pend_q    <= NEUTRAL;
            applied_q <= 1'b1;
            ovr_q     <= 1'b0;
            pwm_q     <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            active_q  <= active_d;
            pend_q    <= pend_d;
            applied_q <= applied_d;
            ovr_q     <= ovr_d;
            pwm_q     <= pwm_d;
            frame_q   <= frame_d;
        end
    end

    assign pwm_o         = pwm_q;
    assign frame_o       = frame_q;
    assign pulse_ticks_o = active_q;
    assign ovr_o         = ovr_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Scoreboard bench for servo_pwm_gen: a frame-position model predicts each cycle's outputs.
module tb_servo_pwm_gen;
    localparam int WIDTH     = 12;
    localparam int PRESCALE  = 2;
    localparam int PERIOD    = 40;
    localparam int MINP      = 4;
    localparam int MAXP      = 12;
    localparam int FRAME_CLK = PERIOD * PRESCALE;
    localparam int NEUT      = MINP + (MAXP - MINP) / 2;

    typedef struct {
        logic        pwm;
        logic        frame;
        logic        ovr;
        logic [15:0] pt;
        int          pos;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset, enable_i, duty_valid_i;
    logic [WIDTH-1:0] duty_i;
    logic             pwm_o, frame_o, ovr_o;
    logic [15:0]      pulse_ticks_o;

    int checks = 0;
    int fails  = 0;
    exp_t q[$];

    // Model: position within the frame in clocks, plus the pending/applied bookkeeping.
    bit m_run = 0, m_applied = 1, m_ovr = 0;
    int m_pos = 0, m_width = NEUT, m_pend = NEUT;

    servo_pwm_gen #(
        .WIDTH(WIDTH), .PRESCALE(PRESCALE), .PERIOD_TICKS(PERIOD),
        .MIN_PULSE(MINP), .MAX_PULSE(MAXP)
    ) dut (
        .clk_i         (clk),
        .reset         (reset),
        .enable_i      (enable_i),
        .duty_i        (duty_i),
        .duty_valid_i  (duty_valid_i),
        .pwm_o         (pwm_o),
        .frame_o       (frame_o),
        .pulse_ticks_o (pulse_ticks_o),
        .ovr_o         (ovr_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin : model
        exp_t e;
        bit   fs, stop;
        int   nv;
        fs = 0;
        nv = 0;
        if (reset) begin
            m_run = 0; m_pos = 0; m_width = NEUT; m_pend = NEUT; m_applied = 1; m_ovr = 0;
        end else begin
            fs   = enable_i && (!m_run || m_pos == FRAME_CLK - 1);
            stop = m_run && m_pos == FRAME_CLK - 1 && !enable_i;
            if (duty_valid_i) nv = MINP + (int'(duty_i) * (MAXP - MINP)) / (1 << WIDTH);
            if (fs) begin
                m_run = 1; m_pos = 0; m_width = m_pend;
            end else if (stop) begin
                m_run = 0; m_pos = 0;
            end else if (m_run) begin
                m_pos++;
            end
            if (duty_valid_i) begin
                if (!m_applied && !fs) m_ovr = 1;
                m_pend = nv; m_applied = 0;
            end else if (fs) begin
                m_applied = 1;
            end
        end
        e.pwm   = m_run && (m_pos < m_width * PRESCALE);
        e.frame = fs;
        e.ovr   = m_ovr;
        e.pt    = 16'(m_width);
        e.pos   = m_pos;
        q.push_back(e);
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (pwm_o !== e.pwm || frame_o !== e.frame || ovr_o !== e.ovr || pulse_ticks_o !== e.pt) begin
                fails++;
                $display("FAIL outputs t=%0t pos=%0d got pwm=%b frame=%b ovr=%b pt=%0d want pwm=%b frame=%b ovr=%b pt=%0d",
                         $time, e.pos, pwm_o, frame_o, ovr_o, pulse_ticks_o, e.pwm, e.frame, e.ovr, e.pt);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input int d);
        duty_i = WIDTH'(d);
        duty_valid_i = 1'b1;
        @(negedge clk);
        duty_valid_i = 1'b0;
    endtask

    // Land on the negedge of the cycle sitting at clock position p of a running frame.
    task automatic wait_pos(input int p);
        int n = 0;
        @(negedge clk);
        while (!(m_run && m_pos == p) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            checks++;
            fails++;
            $display("FAIL wait_pos got timeout want pos=%0d", p);
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        cycles(n);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable_i = 1'b0; duty_valid_i = 1'b0; duty_i = '0;
        cycles(3);
        reset = 1'b0;
        cycles(5);

        // Free-running at neutral width.
        enable_i = 1'b1;
        cycles(3 * FRAME_CLK);

        // Mid-frame updates, including the top of the duty range.
        wait_pos(20); strobe(0);
        cycles(2 * FRAME_CLK);
        wait_pos(20); strobe(4095);
        cycles(2 * FRAME_CLK);

        // Two strobes within one frame: last wins, overrun sticks.
        wait_pos(10); strobe(2048);
        wait_pos(30); strobe(1024);
        cycles(3 * FRAME_CLK);

        // Strobe on the frame-start cycle after a clean reset.
        enable_i = 1'b0;
        do_reset(2);
        enable_i = 1'b1;
        cycles(FRAME_CLK + 10);
        wait_pos(0); strobe(4095);
        cycles(2 * FRAME_CLK);

        // Drop enable mid-frame, then re-enable from idle.
        wait_pos(20); enable_i = 1'b0;
        cycles(FRAME_CLK + 30);
        enable_i = 1'b1;
        cycles(FRAME_CLK + 5);

        // Reset while the pulse is high.
        wait_pos(5); strobe(0);
        wait_pos(3);
        do_reset(1);
        cycles(FRAME_CLK);

        // Randomized strobes, enable toggles and occasional resets.
        for (int i = 0; i < 50; i++) begin
            int r;
            cycles($urandom_range(1, 70));
            r = $urandom_range(0, 11);
            if (r == 0)      enable_i = ~enable_i;
            else if (r == 1) do_reset(1);
            else             strobe($urandom_range(0, 4095));
            if (!enable_i && $urandom_range(0, 3) == 0) enable_i = 1'b1;
        end
        cycles(2 * FRAME_CLK);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/servo_pwm_gen.md
# servo_pwm_gen

Servo pulse generator downstream of the PID controller: takes the controller's WIDTH-bit actuation word and produces a standard hobby-servo PWM frame. Default frame is 20 ms with a 1–2 ms pulse. The block rescales the word into a pulse width and latches it only at frame boundaries, so no runt or stretched pulses ever reach the motor. It also reports frame starts and lost updates for the controller's pacing logic.

## Interface
- WIDTH, 12, bit width of the duty word.
- PRESCALE, 50, clk_i cycles per tick (1 µs at 50 MHz); ≥2.
- PERIOD_TICKS, 20000, ticks per frame.
- MIN_PULSE, 1000, pulse ticks at duty 0.
- MAX_PULSE, 2000, upper pulse bound in ticks; MIN_PULSE < MAX_PULSE < PERIOD_TICKS.

Ports:
- clk_i  in  1  single clock. All logic is on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable_i  in  1  run request.
- duty_i  in  WIDTH  unsigned actuation word from the PID stage.
- duty_valid_i  in  1  one-cycle strobe qualifying duty_i.
- pwm_o  out  1  servo pulse output (registered).
- frame_o  out  1  one-cycle pulse on the first clock of each frame.
- pulse_ticks_o  out  16  pulse width of the current frame (debug/LEDs).
- ovr_o  out  1  sticky flag: an update was overwritten before being applied.

## Operation
- Pulse mapping, computed when duty_valid_i is high:
  - pend = MIN_PULSE + ((duty_i × (MAX_PULSE−MIN_PULSE)) >> WIDTH).
  - The product is full width, with no truncation before the shift.
  - Result range is MIN_PULSE .. MAX_PULSE−1, so no clamp is needed.
- Pending register:
  - Holds the latest mapped value. The last write wins.
  - If a valid arrives while an unapplied value is already pending, set ovr_o (sticky until reset).
- States:
  - IDLE: pwm_o=0, counters held at 0.
  - IDLE→HIGH when enable_i=1.
  - HIGH→LOW when the tick count reaches the active pulse width.
  - LOW→HIGH at the frame end when enable_i=1; LOW→IDLE at the frame end when enable_i=0.
- enable_i is sampled only at the frame end (or in IDLE). Deasserting it mid-frame completes the current frame with the normal pulse.
- Frame start (entry to HIGH from IDLE or from LOW):
  - Active width ← pending value; pending marked applied.
  - frame_o=1 for that cycle; pulse_ticks_o updated.
- Counters:
  - Prescaler runs 0..PRESCALE−1; a tick is asserted on PRESCALE−1.
  - Frame tick counter runs 0..PERIOD_TICKS−1 and wraps to 0 at the frame end.
  - pwm_o=1 exactly while the frame tick count < active width.
- Simultaneous events: if duty_valid_i coincides with a frame-start cycle, the new value is not used for this frame. It becomes pending for the next frame and does not set ovr_o.

## Timing
- Reset values:
  - pwm_o=0, frame_o=0, ovr_o=0, state=IDLE.
  - Pending and active width = MIN_PULSE + ((MAX_PULSE−MIN_PULSE)>>1), i.e. servo neutral (1500 ticks at defaults); pulse_ticks_o shows this value.
  - Pending marked applied.
- Reset mid-frame: pwm_o drops the next cycle and there is no completion of the frame.
- From IDLE:
  - enable_i high at cycle n → frame_o and pwm_o high at cycle n+1.
- Frame length: exactly PERIOD_TICKS×PRESCALE clocks.
- High time: exactly width×PRESCALE clocks, starting the same cycle as frame_o.
- Update latency: a strobe at cycle n is applied at the first frame start strictly after n.
- Outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Package servo_pkg holds:
  - state enum {IDLE, HIGH, LOW};
  - default constants (PRESCALE, PERIOD_TICKS, MIN_PULSE, MAX_PULSE);
  - the neutral-width function.
- Sub-module tick_gen: a parameterised prescaler (clk_i, reset, run, tick). The prescaler is cleared while not running.
- Mapping multiply, pending/ovr logic, FSM and frame counter live in servo_pwm_gen.

## Test plan
Bench parameters: PRESCALE=2, PERIOD_TICKS=40, MIN_PULSE=4, MAX_PULSE=12 (frame = 80 clk).
- Reset, then enable_i=1 with no update → frame_o each 80 clk; pwm_o high 16 clk per frame (neutral 8 ticks); pulse_ticks_o=8.
- duty 0 strobe mid-frame → current frame unchanged, next frame high 8 clk. Then duty 4095 → high 22 clk (11 ticks), never 24.
- Two strobes (2048, then 1024) within one frame → next frame uses 1024 (6 ticks, 12 clk); ovr_o=1 and stays set.
- Strobe on the frame_o cycle → that frame keeps the old width, the next frame uses the new one; ovr_o stays 0.
- enable_i dropped at tick 10 of a frame → the full 80-clk frame completes, then IDLE with pwm_o=0 and no further frame_o. Re-enable → frame_o one cycle later.
- reset asserted while pwm_o=1 → pwm_o=0 next cycle; all outputs at reset values; pending returns to neutral.
